// File: rtl/l1_wb_pkg.sv
// Shared types and default sizes for the L1 instruction/data Wishbone arbiter.
package l1_wb_pkg;
  localparam int L1_ADDR_W    = 32;
  localparam int L1_DATA_W    = 32;
  localparam int L1_BURST_LEN = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;
endpackage

// File: rtl/l1_rr_arb2.sv
// Two-way round-robin grant: bit 0 = instruction port, bit 1 = data port.
module l1_rr_arb2
  import l1_wb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       update_i,
  output logic [1:0] grant_o
);
  owner_e last_q;

  // A tie goes to whichever port was not granted last.
  always_comb begin
    grant_o = req_i;
    if (req_i == 2'b11) grant_o = (last_q == OWN_D) ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= OWN_I;
    else if (update_i) last_q <= grant_o[1] ? OWN_D : OWN_I;
  end
endmodule

// File: rtl/l1_wb_arbiter.sv
// Arbitrates L1 instruction and data requests onto one pipelined Wishbone B4 master,
// issuing critical-word-first wrapping line fills.
module l1_wb_arbiter
  import l1_wb_pkg::*;
#(
  parameter int ADDR_W    = L1_ADDR_W,
  parameter int DATA_W    = L1_DATA_W,
  parameter int BURST_LEN = L1_BURST_LEN
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req_val,
  input  logic [ADDR_W-1:0]   i_req_addr,
  input  logic                i_req_burst,
  output logic                i_req_ack,
  output logic                i_rsp_val,
  output logic [DATA_W-1:0]   i_rsp_data,
  output logic                i_rsp_last,
  output logic                i_rsp_err,
  input  logic                d_req_val,
  input  logic [ADDR_W-1:0]   d_req_addr,
  input  logic                d_req_we,
  input  logic [DATA_W-1:0]   d_req_wdata,
  input  logic [DATA_W/8-1:0] d_req_sel,
  input  logic                d_req_burst,
  output logic                d_req_ack,
  output logic                d_rsp_val,
  output logic [DATA_W-1:0]   d_rsp_data,
  output logic                d_rsp_last,
  output logic                d_rsp_err,
  output logic [ADDR_W-1:0]   wb_adr_o,
  output logic [DATA_W-1:0]   wb_dat_o,
  output logic [DATA_W/8-1:0] wb_sel_o,
  output logic                wb_we_o,
  output logic                wb_cyc_o,
  output logic                wb_stb_o,
  output logic                wb_lock_o,
  input  logic [DATA_W-1:0]   wb_dat_i,
  input  logic                wb_ack_i,
  input  logic                wb_stall_i,
  input  logic                wb_err_i,
  input  logic                wb_rty_i
);
  localparam int SEL_W = DATA_W / 8;
  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam logic [ADDR_W-1:0] WRAP_MASK = ADDR_W'((BURST_LEN - 1) * 4);

  // Only the word-in-line field advances; it wraps inside the line.
  function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [CNT_W-1:0]  k);
    logic [ADDR_W-1:0] inc;
    inc = base + (ADDR_W'(k) << 2);
    return (base & ~WRAP_MASK) | (inc & WRAP_MASK);
  endfunction

  state_e             state_q;
  owner_e             owner_q;
  logic [ADDR_W-1:0]  base_q, adr_q;
  logic [DATA_W-1:0]  dat_q;
  logic [SEL_W-1:0]   sel_q;
  logic               we_q, cyc_q, stb_q;
  logic [CNT_W-1:0]   last_beat_q, stb_cnt_q, ack_cnt_q;

  logic       idle_d;
  logic [1:0] arb_req_d, grant_d;
  logic       ack_fire_d, fail_fire_d, final_ack_d, rsp_fire_d, own_i_d;

  assign idle_d    = (state_q == ST_IDLE);
  assign arb_req_d = idle_d ? {d_req_val, i_req_val} : 2'b00;

  l1_rr_arb2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .req_i    (arb_req_d),
    .update_i (|grant_d),
    .grant_o  (grant_d)
  );

  assign i_req_ack = grant_d[0] & ~rst;
  assign d_req_ack = grant_d[1] & ~rst;

  // Bus responses are qualified by the registered cycle so stray acks never leak out.
  assign ack_fire_d  = cyc_q & wb_ack_i;
  assign fail_fire_d = cyc_q & (wb_err_i | wb_rty_i);
  assign final_ack_d = ack_fire_d & (ack_cnt_q == last_beat_q);
  assign rsp_fire_d  = ack_fire_d | fail_fire_d;
  assign own_i_d     = (owner_q == OWN_I);

  assign i_rsp_val  = rsp_fire_d & own_i_d;
  assign i_rsp_last = (final_ack_d | fail_fire_d) & own_i_d;
  assign i_rsp_err  = fail_fire_d & own_i_d;
  assign i_rsp_data = i_rsp_val ? wb_dat_i : '0;
  assign d_rsp_val  = rsp_fire_d & ~own_i_d;
  assign d_rsp_last = (final_ack_d | fail_fire_d) & ~own_i_d;
  assign d_rsp_err  = fail_fire_d & ~own_i_d;
  assign d_rsp_data = d_rsp_val ? wb_dat_i : '0;

  assign wb_adr_o  = adr_q;
  assign wb_dat_o  = dat_q;
  assign wb_sel_o  = sel_q;
  assign wb_we_o   = we_q;
  assign wb_cyc_o  = cyc_q;
  assign wb_stb_o  = stb_q;
  assign wb_lock_o = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_I;
      base_q      <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      we_q        <= 1'b0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      last_beat_q <= '0;
      stb_cnt_q   <= '0;
      ack_cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|grant_d) begin
            stb_cnt_q <= '0;
            ack_cnt_q <= '0;
            cyc_q     <= 1'b1;
            stb_q     <= 1'b1;
            state_q   <= ST_ADDR;
            if (grant_d[1]) begin
              owner_q     <= OWN_D;
              base_q      <= d_req_addr;
              adr_q       <= d_req_addr;
              we_q        <= d_req_we;
              dat_q       <= d_req_wdata;
              sel_q       <= d_req_we ? d_req_sel : '1;
              last_beat_q <= (d_req_burst && !d_req_we) ? CNT_W'(BURST_LEN - 1) : '0;
            end else begin
              owner_q     <= OWN_I;
              base_q      <= i_req_addr;
              adr_q       <= i_req_addr;
              we_q        <= 1'b0;
              dat_q       <= '0;
              sel_q       <= '1;
              last_beat_q <= i_req_burst ? CNT_W'(BURST_LEN - 1) : '0;
            end
          end
        end
        ST_ADDR, ST_DATA: begin
          // Error/retry and the final ack end the cycle ahead of any strobe bookkeeping.
          if (fail_fire_d || final_ack_d) begin
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            if (ack_fire_d) ack_cnt_q <= ack_cnt_q + CNT_W'(1);
            if (stb_q && !wb_stall_i) begin
              if (stb_cnt_q == last_beat_q) begin
                stb_q   <= 1'b0;
                state_q <= ST_DATA;
              end else begin
                stb_cnt_q <= stb_cnt_q + CNT_W'(1);
                adr_q     <= beat_addr(base_q, stb_cnt_q + CNT_W'(1));
              end
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_l1_wb_arbiter.sv
// Bench for l1_wb_arbiter: scripted Wishbone slave, transaction-level model and literal checks.
module tb_l1_wb_arbiter;
  localparam int BL = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req_val, i_req_burst;
  logic [31:0] i_req_addr;
  logic        i_req_ack, i_rsp_val, i_rsp_last, i_rsp_err;
  logic [31:0] i_rsp_data;
  logic        d_req_val, d_req_we, d_req_burst;
  logic [31:0] d_req_addr, d_req_wdata;
  logic [3:0]  d_req_sel;
  logic        d_req_ack, d_rsp_val, d_rsp_last, d_rsp_err;
  logic [31:0] d_rsp_data;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_cyc_o, wb_stb_o, wb_lock_o;
  logic        wb_ack_i, wb_stall_i, wb_err_i, wb_rty_i;

  l1_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req_val(i_req_val), .i_req_addr(i_req_addr), .i_req_burst(i_req_burst),
    .i_req_ack(i_req_ack), .i_rsp_val(i_rsp_val), .i_rsp_data(i_rsp_data),
    .i_rsp_last(i_rsp_last), .i_rsp_err(i_rsp_err),
    .d_req_val(d_req_val), .d_req_addr(d_req_addr), .d_req_we(d_req_we),
    .d_req_wdata(d_req_wdata), .d_req_sel(d_req_sel), .d_req_burst(d_req_burst),
    .d_req_ack(d_req_ack), .d_rsp_val(d_rsp_val), .d_rsp_data(d_rsp_data),
    .d_rsp_last(d_rsp_last), .d_rsp_err(d_rsp_err),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_lock_o(wb_lock_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_stall_i(wb_stall_i),
    .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] slv_data(input logic [31:0] a);
    return a ^ 32'h5A00_0000;
  endfunction

  // Slave controls and requester handshake flags
  logic        same_mode = 1'b0;
  int          stall_left = 0;
  int          err_at = -1;
  logic        err_is_rty = 1'b0;
  int          rsp_idx = 0;
  logic        spur = 1'b0;
  logic        i_got = 1'b0, d_got = 1'b0;
  logic [31:0] pend[$];

  // Observation logs
  logic [31:0] acc_log[$];
  string       grant_log[$];
  int i_val_cnt, i_last_cnt, i_err_cnt, d_val_cnt, d_last_cnt, d_err_cnt, stall_cnt;

  task automatic clear_logs();
    acc_log.delete();
    i_val_cnt = 0; i_last_cnt = 0; i_err_cnt = 0;
    d_val_cnt = 0; d_last_cnt = 0; d_err_cnt = 0; stall_cnt = 0;
  endtask

  task automatic respond(input logic [31:0] a);
    if (rsp_idx == err_at) begin
      if (err_is_rty) wb_rty_i = 1'b1;
      else wb_err_i = 1'b1;
    end else begin
      wb_ack_i = 1'b1;
    end
    wb_dat_i = slv_data(a);
    rsp_idx++;
  endtask

  always @(negedge clk)
    if (wb_cyc_o && wb_stb_o && !wb_stall_i && !same_mode) pend.push_back(wb_adr_o);

  // Slave and requester drop, driven just after each rising edge
  initial begin
    wb_ack_i = 0; wb_err_i = 0; wb_rty_i = 0; wb_stall_i = 0; wb_dat_i = '0;
    forever begin
      @(posedge clk);
      #1;
      if (i_got) begin i_req_val = 1'b0; i_got = 1'b0; end
      if (d_got) begin d_req_val = 1'b0; d_got = 1'b0; end
      wb_ack_i = 0; wb_err_i = 0; wb_rty_i = 0; wb_dat_i = '0;
      if (!wb_cyc_o) pend.delete();
      if (wb_stb_o && stall_left > 0) begin
        wb_stall_i = 1'b1;
        stall_left--;
      end else begin
        wb_stall_i = 1'b0;
      end
      if (wb_cyc_o) begin
        if (same_mode) begin
          if (wb_stb_o && !wb_stall_i) respond(wb_adr_o);
        end else if (pend.size() > 0) begin
          respond(pend.pop_front());
        end
      end
      if (spur) begin
        wb_ack_i = 1'b1; wb_err_i = 1'b1; wb_dat_i = 32'h1234_5678; spur = 1'b0;
      end
    end
  end

  // Transaction-level model and per-cycle comparison
  logic        mdl_busy = 1'b0, mdl_last_d = 1'b0, mdl_own_d, mdl_we;
  logic [3:0]  mdl_sel;
  logic [31:0] mdl_dat;
  logic [31:0] mdl_addr[BL];
  int          mdl_beats, stb_idx, rsp_cnt;
  logic        ei, ed, ack_in, fail_in, exp_last;
  logic [1:0]  rv, rl, re;
  logic [31:0] rd[2];

  task automatic mdl_start(input logic own_d, input logic [31:0] base, input logic we,
                           input logic burst, input logic [31:0] dat, input logic [3:0] sel);
    int off;
    mdl_own_d = own_d;
    mdl_we    = we;
    mdl_dat   = dat;
    mdl_sel   = we ? sel : 4'hF;
    mdl_beats = (burst && !we) ? BL : 1;
    off = int'((base >> 2) % BL);
    for (int k = 0; k < BL; k++)
      mdl_addr[k] = base - 32'(off * 4) + 32'(((off + k) % BL) * 4);
    stb_idx = 0;
    rsp_cnt = 0;
    mdl_busy = 1'b1;
    mdl_last_d = own_d;
  endtask

  always @(negedge clk) begin
    rv = {d_rsp_val, i_rsp_val};
    rl = {d_rsp_last, i_rsp_last};
    re = {d_rsp_err, i_rsp_err};
    rd[0] = i_rsp_data;
    rd[1] = d_rsp_data;
    chk("lock", wb_lock_o, 0);
    if (i_rsp_val) i_val_cnt++;
    if (i_rsp_last) i_last_cnt++;
    if (i_rsp_err) i_err_cnt++;
    if (d_rsp_val) d_val_cnt++;
    if (d_rsp_last) d_last_cnt++;
    if (d_rsp_err) d_err_cnt++;
    if (rst) begin
      chk("rst_cyc", wb_cyc_o, 0);
      chk("rst_stb", wb_stb_o, 0);
      chk("rst_acks", {i_req_ack, d_req_ack}, 0);
      chk("rst_rsp", rv, 0);
      mdl_busy = 1'b0;
      mdl_last_d = 1'b0;
    end else if (!mdl_busy) begin
      ed = d_req_val && (!i_req_val || !mdl_last_d);
      ei = i_req_val && !ed;
      chk("idle_cyc", wb_cyc_o, 0);
      chk("idle_stb", wb_stb_o, 0);
      chk("i_req_ack", i_req_ack, ei);
      chk("d_req_ack", d_req_ack, ed);
      chk("idle_rsp", rv, 0);
      if (i_req_ack) begin i_got = 1'b1; grant_log.push_back("I"); end
      if (d_req_ack) begin d_got = 1'b1; grant_log.push_back("D"); end
      if (ed) mdl_start(1'b1, d_req_addr, d_req_we, d_req_burst, d_req_wdata, d_req_sel);
      else if (ei) mdl_start(1'b0, i_req_addr, 1'b0, i_req_burst, 32'h0, 4'hF);
    end else begin
      chk("busy_cyc", wb_cyc_o, 1);
      chk("busy_acks", {i_req_ack, d_req_ack}, 0);
      chk("stb", wb_stb_o, stb_idx < mdl_beats);
      if (wb_stb_o && stb_idx < mdl_beats) begin
        chk("adr", wb_adr_o, mdl_addr[stb_idx]);
        chk("we", wb_we_o, mdl_we);
        chk("sel", wb_sel_o, mdl_sel);
        if (mdl_we) chk("dat_o", wb_dat_o, mdl_dat);
      end
      if (wb_stb_o && wb_stall_i) stall_cnt++;
      if (wb_stb_o && !wb_stall_i) begin
        acc_log.push_back(wb_adr_o);
        stb_idx++;
      end
      ack_in   = wb_ack_i;
      fail_in  = wb_err_i | wb_rty_i;
      exp_last = fail_in || (ack_in && rsp_cnt == mdl_beats - 1);
      chk("own_rsp_val", rv[mdl_own_d], ack_in | fail_in);
      chk("own_rsp_last", rl[mdl_own_d], exp_last);
      chk("own_rsp_err", re[mdl_own_d], fail_in);
      if (ack_in || fail_in) chk("rsp_data", rd[mdl_own_d], wb_dat_i);
      chk("other_rsp_val", rv[!mdl_own_d], 0);
      if (exp_last) mdl_busy = 1'b0;
      else if (ack_in) rsp_cnt++;
    end
  end

  task automatic wait_done(input string nm, input int maxc);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while ((mdl_busy || i_req_val || d_req_val) && n < maxc);
    if (n >= maxc) begin
      n_cmp++; n_fail++;
      $display("FAIL %s: timeout after %0d cycles", nm, n);
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic issue_i(input logic [31:0] a, input logic burst);
    i_req_addr = a; i_req_burst = burst; i_req_val = 1'b1;
  endtask

  task automatic issue_d(input logic [31:0] a, input logic we, input logic [31:0] wd,
                         input logic [3:0] sel, input logic burst);
    d_req_addr = a; d_req_we = we; d_req_wdata = wd; d_req_sel = sel;
    d_req_burst = burst; d_req_val = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    i_req_val = 0; i_req_addr = '0; i_req_burst = 0;
    d_req_val = 0; d_req_addr = '0; d_req_we = 0; d_req_wdata = '0; d_req_sel = '0; d_req_burst = 0;
    clear_logs();
    #2;
    chk("reset_adr", wb_adr_o, 0);
    chk("reset_sel", wb_sel_o, 0);
    chk("reset_dat", wb_dat_o, 0);
    chk("reset_we", wb_we_o, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Tie right after reset: D first, then I, then next tie again to D
    @(posedge clk); #1;
    issue_d(32'h40, 1'b0, '0, 4'h0, 1'b0);
    issue_i(32'h80, 1'b0);
    wait_done("tie1", 60);
    @(posedge clk); #1;
    issue_d(32'h44, 1'b0, '0, 4'h0, 1'b0);
    issue_i(32'h84, 1'b0);
    wait_done("tie2", 60);
    chk("grant_cnt", grant_log.size(), 4);
    if (grant_log.size() == 4) begin
      chk("grant0_D", grant_log[0] == "D", 1);
      chk("grant1_I", grant_log[1] == "I", 1);
      chk("grant2_D", grant_log[2] == "D", 1);
      chk("grant3_I", grant_log[3] == "I", 1);
    end

    // I line fill at 0x104, zero-wait slave acking every cycle
    clear_logs(); same_mode = 1'b1; rsp_idx = 0;
    @(posedge clk); #1;
    issue_i(32'h104, 1'b1);
    wait_done("ifill", 60);
    chk("ifill_nacc", acc_log.size(), 4);
    if (acc_log.size() == 4) begin
      chk("ifill_adr0", acc_log[0], 32'h104);
      chk("ifill_adr1", acc_log[1], 32'h108);
      chk("ifill_adr2", acc_log[2], 32'h10C);
      chk("ifill_adr3", acc_log[3], 32'h100);
    end
    chk("ifill_rsp", i_val_cnt, 4);
    chk("ifill_last", i_last_cnt, 1);
    chk("ifill_d_rsp", d_val_cnt, 0);

    // D line fill at 0x3F8 with one-cycle ack latency (exercises the DATA phase)
    clear_logs(); same_mode = 1'b0; rsp_idx = 0;
    @(posedge clk); #1;
    issue_d(32'h3F8, 1'b0, '0, 4'h0, 1'b1);
    wait_done("dfill", 60);
    chk("dfill_nacc", acc_log.size(), 4);
    if (acc_log.size() == 4) begin
      chk("dfill_adr0", acc_log[0], 32'h3F8);
      chk("dfill_adr2", acc_log[2], 32'h3F0);
      chk("dfill_adr3", acc_log[3], 32'h3F4);
    end
    chk("dfill_rsp", d_val_cnt, 4);
    chk("dfill_last", d_last_cnt, 1);

    // D write with burst flag set (must stay single beat) and three stall cycles
    clear_logs(); rsp_idx = 0; stall_left = 3;
    @(posedge clk); #1;
    issue_d(32'h200, 1'b1, 32'hDEADBEEF, 4'h3, 1'b1);
    wait_done("dwr", 60);
    chk("dwr_stalls", stall_cnt, 3);
    chk("dwr_nacc", acc_log.size(), 1);
    if (acc_log.size() == 1) chk("dwr_adr", acc_log[0], 32'h200);
    chk("dwr_rsp", d_val_cnt, 1);
    chk("dwr_last", d_last_cnt, 1);

    // I line fill with bus error on the second beat
    clear_logs(); rsp_idx = 0; err_at = 1; err_is_rty = 1'b0;
    @(posedge clk); #1;
    issue_i(32'h500, 1'b1);
    wait_done("ierr", 60);
    repeat (4) @(posedge clk);
    chk("ierr_rsp", i_val_cnt, 2);
    chk("ierr_err", i_err_cnt, 1);
    chk("ierr_last", i_last_cnt, 1);

    // D single read terminated by retry
    clear_logs(); rsp_idx = 0; err_at = 0; err_is_rty = 1'b1;
    @(posedge clk); #1;
    issue_d(32'h300, 1'b0, '0, 4'h0, 1'b0);
    wait_done("drty", 60);
    chk("drty_err", d_err_cnt, 1);
    chk("drty_last", d_last_cnt, 1);
    err_at = -1; err_is_rty = 1'b0;

    // Stray ack/err with no cycle open must not produce a response
    clear_logs();
    @(posedge clk);
    spur = 1'b1;
    repeat (3) @(posedge clk);
    chk("spur_rsp", i_val_cnt + d_val_cnt, 0);

    // Reset during the DATA phase of a D line fill, then a normal I read
    clear_logs(); rsp_idx = 0;
    @(posedge clk); #1;
    issue_d(32'h600, 1'b0, '0, 4'h0, 1'b1);
    n = 0;
    do begin @(posedge clk); n++; end while (acc_log.size() < 4 && n < 40);
    if (n >= 40) begin
      n_cmp++; n_fail++;
      $display("FAIL rst_wait: timeout waiting for strobes");
    end
    #2;
    chk("pre_rst_cyc", wb_cyc_o, 1);
    chk("pre_rst_stb", wb_stb_o, 0);
    rst = 1'b1;
    #1;
    chk("rst_now_cyc", wb_cyc_o, 0);
    chk("rst_now_stb", wb_stb_o, 0);
    chk("rst_now_adr", wb_adr_o, 0);
    chk("rst_now_drsp", {d_rsp_val, d_rsp_last}, 0);
    clear_logs();
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b0;
    rsp_idx = 0;
    @(posedge clk); #1;
    issue_i(32'h700, 1'b0);
    wait_done("post_rst", 60);
    chk("post_rst_d_rsp", d_val_cnt, 0);
    chk("post_rst_i_rsp", i_val_cnt, 1);
    chk("post_rst_i_last", i_last_cnt, 1);
    chk("post_rst_nacc", acc_log.size(), 1);
    if (acc_log.size() == 1) chk("post_rst_adr", acc_log[0], 32'h700);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
